// File: rtl/f_deser_pkg.sv
// Shared types and constants for the f_deser serial-to-parallel deserializer.
package f_deser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Counter must hold 0..w-1; bit w completes the word without being counted.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/f_deser_fifo.sv
// Synchronous FIFO for f_deser; head output holds its last value while empty.
module f_deser_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic [W-1:0]  last_q;
    logic          do_pop, do_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot on the same edge, so a full FIFO still accepts the write.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? last_q : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (!empty_o) last_q <= mem_q[rd_q[AW-1:0]];
        end
    end

endmodule

// File: rtl/f_deser.sv
// Serial-to-parallel deserializer with output FIFO and sticky overflow.
// Optional even-parity bit per word: define F_DESER_PARITY_EN.
module f_deser
    import f_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             F,
    input  logic             EN,
    input  logic             CLR,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    input  logic             READY,
    output logic             OVF,
    output logic             PERR
);

    localparam int CW = cnt_width(WIDTH);
`ifdef F_DESER_PARITY_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             push, pop, full, empty, ovf_q;
    logic [FW-1:0]    wdata, head;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        push    = 1'b0;
        wdata   = '0;
        if (CLR) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (EN) begin
            case (state_q)
                IDLE: begin
                    sr_d    = {{(WIDTH-1){1'b0}}, F};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sr_d = {sr_q[WIDTH-2:0], F};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d = '0;
`ifdef F_DESER_PARITY_EN
                        state_d = PAR;
`else
                        state_d = IDLE;
                        push    = 1'b1;
                        wdata   = {sr_q[WIDTH-2:0], F};
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PAR: begin
                    state_d = IDLE;
`ifdef F_DESER_PARITY_EN
                    push  = 1'b1;
                    wdata = {sr_q, ^{sr_q, F}};
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pop = READY & ~empty;

    f_deser_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (wdata),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign DATA  = head[FW-1 -: WIDTH];
    assign VALID = ~empty;
    assign OVF   = ovf_q;
`ifdef F_DESER_PARITY_EN
    assign PERR  = head[0] & ~empty;
`else
    assign PERR  = 1'b0;
`endif

endmodule

// File: doc/f_deser.md
F_DESER -- requirements
Module: f_deser

Interface
REQ-001 Parameter WIDTH, default 8, data bits per word (2..16).
REQ-002 Parameter DEPTH, default 4, output FIFO entries (power of 2, 2..16).
REQ-003 CLK  input  1  the only clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 F  input  1  serial bit from the upstream toggle/load flop, synchronous to CLK.
REQ-006 EN  input  1  capture enable; F is sampled only on edges where EN=1.
REQ-007 CLR  input  1  synchronous discard of the partial word; has no effect on FIFO contents.
REQ-008 DATA  output  WIDTH  head-of-FIFO word, MSB = first bit captured.
REQ-009 VALID  output  1  FIFO non-empty.
REQ-010 READY  input  1  consumer accepts DATA on an edge where VALID=1 and READY=1.
REQ-011 OVF  output  1  sticky overflow flag.
REQ-012 PERR  output  1  parity error flag for the head word (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and, with the macro, PAR.
REQ-014 In IDLE with EN=1: F is loaded into the shift register bit 0, the count is set to 1, and the FSM moves to SHIFT.
REQ-015 In SHIFT with EN=1: the shift register shifts left, F enters bit 0, and the count increments.
REQ-016 In SHIFT with EN=0: the shift register and count hold, with no timeout.
REQ-017 On the edge that captures bit WIDTH, the word SHALL be written into the FIFO on that same edge; VALID rises on the next cycle when the FIFO was empty.
REQ-018 After that write, the FSM returns to IDLE (or goes to PAR with the macro) and the count is set to 0.
REQ-019 Back-to-back words with EN held at 1 SHALL lose no bits: the edge after the last bit captures bit 1 of the next word.
REQ-020 CLR=1 SHALL force IDLE and count 0 and discard the partial word; CLR has priority over EN.
REQ-021 FIFO full at a write edge with no pop: the word is dropped and OVF is set; OVF clears only on reset.
REQ-022 FIFO full with a pop and a write on the same edge: both take effect, occupancy is unchanged and OVF is not set.
REQ-023 FIFO empty: VALID=0, DATA holds its last value, and READY is ignored.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.

Reset
REQ-025 RST_N=0 SHALL immediately (asynchronously) force: IDLE, count 0, shift register 0, FIFO empty, DATA=0, VALID=0, OVF=0, PERR=0.
REQ-026 Reset asserted mid-word or with a non-empty FIFO SHALL discard all words.
REQ-027 Capture SHALL resume with the first edge where EN=1 after RST_N rises.

Configuration
REQ-028 Macro F_DESER_PARITY_EN defined: after bit WIDTH, the FSM enters PAR.
REQ-029 In PAR, the next EN=1 edge samples the parity bit, and the word is written on that edge rather than in REQ-017.
REQ-030 Even parity is expected over the data bits plus the parity bit; each FIFO entry carries one error bit, and PERR shows the head entry's error bit, qualified by VALID.
REQ-031 Macro undefined: there is no PAR state and no FIFO error bit, and PERR is tied to 0.

Structure
REQ-032 Package f_deser_pkg SHALL hold the state enum (IDLE, SHIFT, PAR), default WIDTH/DEPTH constants, and the count width function.
REQ-033 The FIFO SHALL be a separate sub-module f_deser_fifo (parameterised width and depth; push, pop, full, empty, head); f_deser instantiates it once.

Verification
REQ-034 Reset, then EN=1 for 8 cycles with F=1,0,1,1,0,0,1,0 -> DATA=8'hB2, VALID=1 one cycle after the 8th edge.
REQ-035 EN pattern 1,1,0,0,0,1,1,1,1,1,1 with bits 1,1,x,x,x,0,0,0,0,0,1 -> DATA=8'hC1; the paused cycles add no bits.
REQ-036 READY=0 while 5 words stream with DEPTH=4 -> 4 words retained in order, 5th dropped, OVF=1; then READY=1 with EN=0 -> 4 words drain and VALID=0.
REQ-037 Full FIFO with READY=1 on the same edge as the 5th word's last bit -> no OVF, 5th word is the last one read.
REQ-038 RST_N low after 3 bits, released, then 8 bits 8'h5A -> only 8'h5A emerges.
REQ-039 With F_DESER_PARITY_EN: 8'h0F with parity 0 -> PERR=0; 8'h07 with parity 0 -> PERR=1 while the word is at the FIFO head.
